// File: rtl/me_mem_rd_split_ctrl_if.sv
// Pipeline and data-cache signals of the memory-stage read requester.
// The slave modport is the requester; the master modport is its environment.
interface me_mem_rd_split_ctrl_if #(
  parameter int LINE_W = 128,
  parameter int DATA_W = 64
);
  logic              V;
  logic              MEM_RD;
  logic [31:0]       MEM_RD_ADDR;
  logic [1:0]        MEM_SIZE;
  logic              EXC_EXIST;
  logic              FLUSH;
  logic              LD_EX;
  logic              DC_REQ_V;
  logic [31:0]       DC_REQ_ADDR;
  logic              DC_REQ_RDY;
  logic              DC_RSP_V;
  logic [LINE_W-1:0] DC_RSP_DATA;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_DATA_V;
  logic              ME_STALL;

  modport master (
    output V, MEM_RD, MEM_RD_ADDR, MEM_SIZE, EXC_EXIST, FLUSH, LD_EX,
           DC_REQ_RDY, DC_RSP_V, DC_RSP_DATA,
    input  DC_REQ_V, DC_REQ_ADDR, RD_DATA, RD_DATA_V, ME_STALL
  );

  modport slave (
    input  V, MEM_RD, MEM_RD_ADDR, MEM_SIZE, EXC_EXIST, FLUSH, LD_EX,
           DC_REQ_RDY, DC_RSP_V, DC_RSP_DATA,
    output DC_REQ_V, DC_REQ_ADDR, RD_DATA, RD_DATA_V, ME_STALL
  );
endinterface

// File: rtl/me_mem_rd_split_ctrl.sv
// Memory-stage read requester: issues one or two line reads per access and
// merges the bytes into a right-justified, zero-extended operand.
module me_mem_rd_split_ctrl #(
  parameter int LINE_LOG2 = 4,
  parameter int LINE_W    = 8 << LINE_LOG2,
  parameter int DATA_W    = 64
) (
  input logic                   CLK,
  input logic                   RST,
  me_mem_rd_split_ctrl_if.slave bus
);

  localparam int OFF_W      = LINE_LOG2;
  localparam int TAG_W      = 32 - LINE_LOG2;
  localparam int LINE_BYTES = 1 << LINE_LOG2;

  typedef enum logic [2:0] {
    IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE, DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q;
  logic [1:0]          size_q;
  logic                split_q;
  logic [LINE_W-1:0]   line0_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic                go, accept, cap_lo, cap_final, split_d;
  logic [OFF_W:0]      span;
  logic [2*LINE_W-1:0] cat, shifted;
  logic [DATA_W-1:0]   mask, merged;

  assign go      = bus.V & bus.MEM_RD & ~bus.EXC_EXIST & ~bus.FLUSH;
  assign span    = {1'b0, bus.MEM_RD_ADDR[OFF_W-1:0]} + ((OFF_W+1)'(1) << bus.MEM_SIZE);
  assign split_d = span > (OFF_W+1)'(LINE_BYTES);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Flush outranks everything; an already-accepted request still owes a response (DRAIN).
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cap_lo    = 1'b0;
    cap_final = 1'b0;
    unique case (state_q)
      IDLE: if (go) begin
        state_d = REQ_LO;
        accept  = 1'b1;
      end
      REQ_LO: begin
        if (bus.FLUSH)           state_d = bus.DC_REQ_RDY ? DRAIN : IDLE;
        else if (bus.DC_REQ_RDY) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (bus.DC_RSP_V) begin
          if (bus.FLUSH) state_d = IDLE;
          else begin
            cap_lo = 1'b1;
            if (split_q) state_d = REQ_HI;
            else begin
              state_d   = DONE;
              cap_final = 1'b1;
            end
          end
        end else if (bus.FLUSH) state_d = DRAIN;
      end
      REQ_HI: begin
        if (bus.FLUSH)           state_d = bus.DC_REQ_RDY ? DRAIN : IDLE;
        else if (bus.DC_REQ_RDY) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.DC_RSP_V) begin
          if (bus.FLUSH) state_d = IDLE;
          else begin
            state_d   = DONE;
            cap_final = 1'b1;
          end
        end else if (bus.FLUSH) state_d = DRAIN;
      end
      DONE: begin
        if (bus.FLUSH) state_d = IDLE;
        else if (bus.LD_EX) begin
          if (go) begin
            state_d = REQ_LO;
            accept  = 1'b1;
          end else state_d = IDLE;
        end
      end
      DRAIN:   if (bus.DC_RSP_V) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // {line1, line0} shifted down by the offset puts byte off+i at operand byte i.
  always_comb begin
    cat     = {bus.DC_RSP_DATA, (state_q == WAIT_HI) ? line0_q : bus.DC_RSP_DATA};
    shifted = cat >> {addr_q[OFF_W-1:0], 3'b000};
    mask    = '1;
    mask    = mask >> (DATA_W - (8 << size_q));
    merged  = shifted[DATA_W-1:0] & mask;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q    <= '0;
      size_q    <= '0;
      split_q   <= 1'b0;
      line0_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.MEM_RD_ADDR;
        size_q  <= bus.MEM_SIZE;
        split_q <= split_d;
      end
      if (cap_lo)    line0_q   <= bus.DC_RSP_DATA;
      if (cap_final) rd_data_q <= merged;
    end
  end

  always_comb begin
    bus.DC_REQ_V    = 1'b0;
    bus.DC_REQ_ADDR = '0;
    bus.RD_DATA_V   = 1'b0;
    bus.ME_STALL    = 1'b0;
    unique case (state_q)
      IDLE:    bus.ME_STALL = go;
      REQ_LO: begin
        bus.DC_REQ_V    = 1'b1;
        bus.DC_REQ_ADDR = {addr_q[31:OFF_W], OFF_W'(0)};
        bus.ME_STALL    = 1'b1;
      end
      REQ_HI: begin
        bus.DC_REQ_V    = 1'b1;
        bus.DC_REQ_ADDR = {addr_q[31:OFF_W] + TAG_W'(1), OFF_W'(0)};
        bus.ME_STALL    = 1'b1;
      end
      WAIT_LO, WAIT_HI, DRAIN: bus.ME_STALL = 1'b1;
      DONE:    bus.RD_DATA_V = 1'b1;
      default: ;
    endcase
  end

  assign bus.RD_DATA = rd_data_q;

  rsp_only_when_owed: assert property (@(posedge CLK) disable iff (!RST)
    bus.DC_RSP_V |-> (state_q inside {WAIT_LO, WAIT_HI, DRAIN}));

endmodule

// File: tb/tb_me_mem_rd_split_ctrl.sv
// Directed bench for me_mem_rd_split_ctrl: per-cycle vector table plus
// hand-written flush-drain, DONE-hold and reset-mid-access sequences.
module tb_me_mem_rd_split_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  me_mem_rd_split_ctrl_if #(.LINE_W(128), .DATA_W(64)) bus ();

  me_mem_rd_split_ctrl #(.LINE_LOG2(4), .LINE_W(128), .DATA_W(64)) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  localparam logic [127:0] Z128 = '0;
  localparam logic [127:0] LA = 128'hEEEEEEEE_EEEEEEEE_44332211_EEEEEEEE;
  localparam logic [127:0] LB = 128'hAABB5555_55555555_55555555_55555555;
  localparam logic [127:0] LC = 128'h66666666_66666666_66666666_6666DDCC;
  localparam logic [127:0] LD = 128'h87654321_77777777_77777777_77777777;
  localparam logic [127:0] LE = 128'h88888888_88888888_88888888_FEDCBA98;

  typedef struct {
    string        tag;
    logic         v, rd, exc, flush, ld, rdy, rsp;
    logic [31:0]  addr;
    logic [1:0]   size;
    logic [127:0] data;
    logic         e_req, e_rdv, e_stall, chk_data;
    logic [31:0]  e_addr;
    logic [63:0]  e_data;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic vec_t mk(input string tag, input int v, input int rd,
                              input logic [31:0] addr, input int size, input int exc,
                              input int flush, input int ld, input int rdy, input int rsp,
                              input logic [127:0] data, input int e_req,
                              input logic [31:0] e_addr, input int e_rdv, input int e_stall,
                              input int chk, input logic [63:0] e_data);
    vec_t t;
    t.tag = tag;  t.v = v[0];  t.rd = rd[0];  t.addr = addr;  t.size = size[1:0];
    t.exc = exc[0];  t.flush = flush[0];  t.ld = ld[0];  t.rdy = rdy[0];  t.rsp = rsp[0];
    t.data = data;  t.e_req = e_req[0];  t.e_addr = e_addr;  t.e_rdv = e_rdv[0];
    t.e_stall = e_stall[0];  t.chk_data = chk[0];  t.e_data = e_data;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.V = t.v;  bus.MEM_RD = t.rd;  bus.MEM_RD_ADDR = t.addr;  bus.MEM_SIZE = t.size;
    bus.EXC_EXIST = t.exc;  bus.FLUSH = t.flush;  bus.LD_EX = t.ld;
    bus.DC_REQ_RDY = t.rdy;  bus.DC_RSP_V = t.rsp;  bus.DC_RSP_DATA = t.data;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step(input vec_t t);
    @(posedge clk);
    #1 drive(t);
    #1;
    check({t.tag, ".req_v"},    64'(bus.DC_REQ_V),    64'(t.e_req));
    check({t.tag, ".req_addr"}, 64'(bus.DC_REQ_ADDR), 64'(t.e_addr));
    check({t.tag, ".rd_v"},     64'(bus.RD_DATA_V),   64'(t.e_rdv));
    check({t.tag, ".stall"},    64'(bus.ME_STALL),    64'(t.e_stall));
    if (t.chk_data) check({t.tag, ".rd_data"}, bus.RD_DATA, t.e_data);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_v"},    64'(bus.DC_REQ_V),    64'h0);
    check({tag, ".req_addr"}, 64'(bus.DC_REQ_ADDR), 64'h0);
    check({tag, ".rd_data"},  bus.RD_DATA,          64'h0);
    check({tag, ".rd_v"},     64'(bus.RD_DATA_V),   64'h0);
    check({tag, ".stall"},    64'(bus.ME_STALL),    64'h0);
  endtask

  vec_t nop;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        tag         v rd addr          sz ex fl ld ry rs data  | req addr          rdv stl chk data
    tbl.push_back(mk("t1c0", 1, 1, 32'h1000_0004, 2, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t1c1", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 1, 32'h1000_0000, 0, 1, 0, 64'h0));
    tbl.push_back(mk("t1c2", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, LA,   0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t1c3", 0, 0, 32'h0,         0, 0, 0, 1, 0, 0, Z128, 0, 32'h0,         1, 0, 1, 64'h4433_2211));
    tbl.push_back(mk("t1c4", 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));
    tbl.push_back(mk("t2c0", 1, 1, 32'h2000_000E, 2, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t2c1", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 1, 32'h2000_0000, 0, 1, 0, 64'h0));
    tbl.push_back(mk("t2c2", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, LB,   0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t2c3", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 1, 32'h2000_0010, 0, 1, 0, 64'h0));
    tbl.push_back(mk("t2c4", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, LC,   0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t2c5", 0, 0, 32'h0,         0, 0, 0, 1, 0, 0, Z128, 0, 32'h0,         1, 0, 1, 64'hDDCC_AABB));
    tbl.push_back(mk("t2c6", 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));
    tbl.push_back(mk("t3c0", 1, 1, 32'hFFFF_FFFC, 3, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t3c1", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 1, 32'hFFFF_FFF0, 0, 1, 0, 64'h0));
    tbl.push_back(mk("t3c2", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, LD,   0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t3c3", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 1, 32'h0000_0000, 0, 1, 0, 64'h0));
    tbl.push_back(mk("t3c4", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, LE,   0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t3c5", 0, 0, 32'h0,         0, 0, 1, 0, 0, 0, Z128, 0, 32'h0,         1, 0, 1, 64'hFEDC_BA98_8765_4321));
    tbl.push_back(mk("t3c6", 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));
    tbl.push_back(mk("t4c0", 1, 1, 32'h7000_000F, 3, 1, 0, 0, 1, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));
    tbl.push_back(mk("t4c1", 1, 1, 32'h7000_000F, 3, 1, 0, 0, 1, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));
    tbl.push_back(mk("t4c2", 1, 0, 32'h7000_0000, 2, 0, 0, 0, 1, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));
    tbl.push_back(mk("t4c3", 1, 1, 32'h7000_0000, 2, 0, 1, 0, 1, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));
    tbl.push_back(mk("t7c0", 1, 1, 32'h6000_0001, 1, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    tbl.push_back(mk("t7c1", 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, Z128, 1, 32'h6000_0000, 0, 1, 0, 64'h0));
    tbl.push_back(mk("t7c2", 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, Z128, 1, 32'h6000_0000, 0, 1, 0, 64'h0));
    tbl.push_back(mk("t7c3", 0, 0, 32'h0,         0, 0, 1, 0, 0, 0, Z128, 1, 32'h6000_0000, 0, 1, 0, 64'h0));
    tbl.push_back(mk("t7c4", 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));

    nop = mk("nop", 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, Z128, 0, 32'h0, 0, 0, 0, 64'h0);

    rst_n = 1'b0;
    drive(nop);
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Flush while waiting for the low line; response arrives three cycles later.
    step(mk("t5c0", 1, 1, 32'h3000_0000, 0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    step(mk("t5c1", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 1, 32'h3000_0000, 0, 1, 0, 64'h0));
    step(mk("t5c2", 0, 0, 32'h0,         0, 0, 1, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    step(mk("t5c3", 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    step(mk("t5c4", 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    step(mk("t5c5", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, LA,   0, 32'h0,         0, 1, 0, 64'h0));
    step(mk("t5c6", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));
    step(mk("t5c7", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 0, 32'h0,         0, 0, 0, 64'h0));

    // DONE held without LD_EX, then back-to-back GO, then reset in WAIT_HI.
    step(mk("t6c0", 1, 1, 32'h4000_0008, 3, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    step(mk("t6c1", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 1, 32'h4000_0000, 0, 1, 0, 64'h0));
    step(mk("t6c2", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, LD,   0, 32'h0,         0, 1, 0, 64'h0));
    for (int k = 0; k < 4; k++)
      step(mk("t6hold", 0, 0, 32'h0,     0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         1, 0, 1, 64'h8765_4321_7777_7777));
    step(mk("t6c7", 1, 1, 32'h5000_000C, 3, 0, 0, 1, 0, 0, Z128, 0, 32'h0,         1, 0, 1, 64'h8765_4321_7777_7777));
    step(mk("t6c8", 0, 0, 32'h0,         0, 0, 0, 0, 1, 0, Z128, 1, 32'h5000_0000, 0, 1, 0, 64'h0));
    step(mk("t6c9", 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, LB,   0, 32'h0,         0, 1, 0, 64'h0));
    step(mk("t6c10", 0, 0, 32'h0,        0, 0, 0, 0, 1, 0, Z128, 1, 32'h5000_0010, 0, 1, 0, 64'h0));
    step(mk("t6c11", 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, Z128, 0, 32'h0,         0, 1, 0, 64'h0));
    #1 rst_n = 1'b0;
    #1 check_all_zero("t6rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(nop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
